// File: rtl/vga_framebuffer_writer.sv
// Rectangle fill engine: accepts a rectangle command, then streams incoming
// pixels into a linear framebuffer (addr = y*H_RES + x), row-major order.
module vga_framebuffer_writer #(
    parameter int H_RES  = 640,
    parameter int V_RES  = 480,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [9:0]        cmd_x0,
    input  logic [9:0]        cmd_y0,
    input  logic [9:0]        cmd_w,
    input  logic [9:0]        cmd_h,
    input  logic              pix_valid,
    output logic              pix_ready,
    input  logic [DATA_W-1:0] pix_data,
    output logic              fb_we,
    output logic [18:0]       fb_addr,
    output logic [DATA_W-1:0] fb_data,
    input  logic              abort,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam int          ADDR_W = 19;
    localparam logic [10:0] H_LIM  = 11'(H_RES);
    localparam logic [10:0] V_LIM  = 11'(V_RES);
    localparam logic [18:0] H_STEP = 19'(H_RES);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state, state_nx;

    // Latched rectangle geometry and walk position
    logic [9:0]        x0_q;
    logic [9:0]        w_q;
    logic [9:0]        h_q;
    logic [9:0]        col_q;
    logic [9:0]        row_q;
    logic [ADDR_W-1:0] row_base_q;

    // Handshakes and command qualification
    logic              cmd_hs;
    logic              pix_hs;
    logic [10:0]       x_end;
    logic [10:0]       y_end;
    logic              cmd_bad;
    logic              cmd_accept;
    logic              last_col;
    logic              last_row;
    logic              in_frame;
    logic [ADDR_W-1:0] row_base_init;

    // y*H_RES as a sum of shifted copies of y, one per set bit of H_RES
    // (640 -> y<<9 + y<<7), so no multiplier is inferred.
    function automatic logic [ADDR_W-1:0] mul_h_res(input logic [9:0] y);
        logic [ADDR_W-1:0] acc;
        acc = '0;
        for (int unsigned i = 0; i < ADDR_W; i++) begin
            if (((H_RES >> i) & 1) != 0) begin
                acc = acc + (ADDR_W'(y) << i);
            end
        end
        return acc;
    endfunction

    // Handshake and bounds decode; end coordinates kept at 11 bits so
    // x0+w cannot wrap before the comparison.
    always_comb begin
        cmd_hs        = cmd_valid && cmd_ready;
        pix_hs        = pix_valid && pix_ready;
        x_end         = {1'b0, cmd_x0} + {1'b0, cmd_w};
        y_end         = {1'b0, cmd_y0} + {1'b0, cmd_h};
        cmd_bad       = (cmd_w == '0) || (cmd_h == '0) ||
                        (x_end > H_LIM) || (y_end > V_LIM);
        cmd_accept    = cmd_hs && !cmd_bad;
        last_col      = (col_q == (w_q - 10'd1));
        last_row      = (row_q == (h_q - 10'd1));
        in_frame      = (({1'b0, x0_q} + {1'b0, col_q}) < H_LIM);
        row_base_init = mul_h_res(cmd_y0) + ADDR_W'(cmd_x0);
    end

    // Combinational status / ready outputs derived from the state
    always_comb begin
        cmd_ready = 1'b0;
        pix_ready = 1'b0;
        busy      = 1'b0;
        case (state)
            IDLE:    cmd_ready = 1'b1;
            RUN: begin
                pix_ready = !abort;
                busy      = 1'b1;
            end
            default: ;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state logic
    always_comb begin
        state_nx = state;
        case (state)
            IDLE: begin
                if (cmd_accept) begin
                    state_nx = RUN;
                end
            end
            RUN: begin
                if (abort) begin
                    state_nx = IDLE;
                end else if (pix_hs && last_col && last_row) begin
                    state_nx = DONE;
                end
            end
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Geometry latch on accept; column/row walk on each pixel handshake
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x0_q       <= '0;
            w_q        <= '0;
            h_q        <= '0;
            col_q      <= '0;
            row_q      <= '0;
            row_base_q <= '0;
        end else if (state == IDLE) begin
            if (cmd_accept) begin
                x0_q       <= cmd_x0;
                w_q        <= cmd_w;
                h_q        <= cmd_h;
                col_q      <= '0;
                row_q      <= '0;
                row_base_q <= row_base_init;
            end
        end else if (pix_hs) begin
            if (last_col) begin
                col_q      <= '0;
                row_q      <= row_q + 10'd1;
                row_base_q <= row_base_q + H_STEP;
            end else begin
                col_q      <= col_q + 10'd1;
            end
        end
    end

    // Framebuffer write port: one-cycle registered copy of each handshake;
    // address/data hold between writes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fb_we   <= 1'b0;
            fb_addr <= '0;
            fb_data <= '0;
        end else begin
            fb_we <= pix_hs && in_frame;
            if (pix_hs) begin
                fb_addr <= row_base_q + ADDR_W'(col_q);
                fb_data <= pix_data;
            end
        end
    end

    // Completion and rejection pulses, each one cycle wide
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            done <= 1'b0;
            err  <= 1'b0;
        end else begin
            done <= (state == DONE);
            err  <= cmd_hs && cmd_bad;
        end
    end

endmodule

// File: tb/tb_vga_framebuffer_writer.sv
// Self-checking bench for vga_framebuffer_writer: a pixel-index reference
// model checked every cycle, plus directed literal expectations.
module tb_vga_framebuffer_writer;

    localparam int H  = 640;
    localparam int V  = 480;
    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic [9:0]    cmd_x0 = '0;
    logic [9:0]    cmd_y0 = '0;
    logic [9:0]    cmd_w = '0;
    logic [9:0]    cmd_h = '0;
    logic          pix_valid = 1'b0;
    logic          pix_ready;
    logic [DW-1:0] pix_data = '0;
    logic          fb_we;
    logic [18:0]   fb_addr;
    logic [DW-1:0] fb_data;
    logic          abort = 1'b0;
    logic          busy;
    logic          done;
    logic          err;

    vga_framebuffer_writer #(.H_RES(H), .V_RES(V), .DATA_W(DW)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_x0(cmd_x0), .cmd_y0(cmd_y0), .cmd_w(cmd_w), .cmd_h(cmd_h),
        .pix_valid(pix_valid), .pix_ready(pix_ready), .pix_data(pix_data),
        .fb_we(fb_we), .fb_addr(fb_addr), .fb_data(fb_data),
        .abort(abort), .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    // Reference model: mode 0 idle, 1 running, 2 finishing
    int m_mode = 0;
    int m_x0 = 0, m_y0 = 0, m_w = 1, m_h = 1, m_k = 0;
    int exp_we = 0, exp_addr = 0, exp_data = 0, exp_done = 0, exp_err = 0;

    // Observation logs
    int wlog[$];
    int dlog[$];
    int last_we_cyc = 0, done_cyc = 0, done_cnt = 0, err_cnt = 0;

    task automatic chk(input string nm, input longint act, input longint want);
        checks++;
        if (act != want) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d (t=%0t)", nm, act, want, $time);
        end
    endtask

    function automatic bit legal(input int x0, input int y0, input int w, input int h);
        return (w > 0) && (h > 0) && (x0 + w <= H) && (y0 + h <= V);
    endfunction

    // Compare against the model, log writes, then advance the model using the
    // inputs that will be sampled at the next rising edge.
    initial begin
        bit hs;
        forever begin
            @(negedge clk);
            cyc++;
            if (!rst_n) begin
                m_mode = 0; m_k = 0;
                exp_we = 0; exp_addr = 0; exp_data = 0; exp_done = 0; exp_err = 0;
            end
            chk("cmd_ready", cmd_ready, m_mode == 0);
            chk("pix_ready", pix_ready, (m_mode == 1) && !abort);
            chk("busy", busy, m_mode == 1);
            chk("fb_we", fb_we, exp_we);
            chk("fb_addr", fb_addr, exp_addr);
            chk("fb_data", fb_data, exp_data);
            chk("done", done, exp_done);
            chk("err", err, exp_err);
            chk("addr_range", fb_addr <= H * V - 1, 1);
            if (fb_we) begin
                wlog.push_back(int'(fb_addr));
                dlog.push_back(int'(fb_data));
                last_we_cyc = cyc;
            end
            if (done) begin done_cnt++; done_cyc = cyc; end
            if (err) err_cnt++;
            if (rst_n) begin
                hs = (m_mode == 1) && pix_valid && !abort;
                exp_we   = hs;
                exp_done = (m_mode == 2);
                exp_err  = (m_mode == 0) && cmd_valid &&
                           !legal(int'(cmd_x0), int'(cmd_y0), int'(cmd_w), int'(cmd_h));
                if (hs) begin
                    exp_addr = (m_y0 + m_k / m_w) * H + m_x0 + m_k % m_w;
                    exp_data = int'(pix_data);
                    m_k++;
                end
                case (m_mode)
                    0: if (cmd_valid && legal(int'(cmd_x0), int'(cmd_y0), int'(cmd_w), int'(cmd_h))) begin
                        m_x0 = int'(cmd_x0); m_y0 = int'(cmd_y0);
                        m_w = int'(cmd_w); m_h = int'(cmd_h);
                        m_k = 0; m_mode = 1;
                    end
                    1: if (abort) m_mode = 0;
                       else if (hs && m_k == m_w * m_h) m_mode = 2;
                    default: m_mode = 0;
                endcase
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        pix_valid = 1'b0; abort = 1'b0; cmd_valid = 1'b0;
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic clear_logs();
        wlog.delete(); dlog.delete();
        done_cnt = 0; err_cnt = 0;
    endtask

    task automatic send_cmd(input int x0, input int y0, input int w, input int h);
        cmd_x0 = 10'(x0); cmd_y0 = 10'(y0); cmd_w = 10'(w); cmd_h = 10'(h);
        cmd_valid = 1'b1;
        step();
        cmd_valid = 1'b0;
    endtask

    task automatic run_pix(input int density, input int abort_pct, input bit noise, input int budget);
        int n;
        n = 0;
        do begin
            pix_valid = ($urandom_range(0, 99) < density);
            pix_data  = DW'($urandom);
            abort     = ($urandom_range(0, 99) < abort_pct);
            if (noise) begin
                cmd_valid = 1'($urandom_range(0, 1));
                cmd_x0 = 10'($urandom); cmd_y0 = 10'($urandom);
                cmd_w  = 10'($urandom); cmd_h  = 10'($urandom);
            end
            step();
            n++;
        end while (m_mode != 0 && n < budget);
        pix_valid = 1'b0; abort = 1'b0; cmd_valid = 1'b0;
        chk("run_budget", n < budget, 1);
    endtask

    initial begin
        int pat[6];
        int vals[6];
        pat  = '{1, 0, 1, 0, 1, 1};
        vals = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};

        // Reset state
        #1 rst_n = 1'b0;
        step(); step();
        chk("rst_cmd_ready", cmd_ready, 1);
        chk("rst_pix_ready", pix_ready, 0);
        chk("rst_fb_addr", fb_addr, 0);
        step();
        rst_n = 1'b1;
        idle(2);

        // Small 3x2 rectangle, continuous pixels
        clear_logs();
        send_cmd(10, 2, 3, 2);
        run_pix(100, 0, 0, 100);
        idle(3);
        chk("r34_count", wlog.size(), 6);
        if (wlog.size() == 6) begin
            chk("r34_a0", wlog[0], 1290); chk("r34_a1", wlog[1], 1291);
            chk("r34_a2", wlog[2], 1292); chk("r34_a3", wlog[3], 1930);
            chk("r34_a4", wlog[4], 1931); chk("r34_a5", wlog[5], 1932);
        end
        chk("r34_done_cnt", done_cnt, 1);
        chk("r34_done_lag", done_cyc - last_we_cyc, 1);

        // Stalled pixel stream
        clear_logs();
        send_cmd(0, 0, 4, 1);
        for (int i = 0; i < 6; i++) begin
            pix_valid = pat[i][0];
            pix_data  = DW'(vals[i]);
            step();
        end
        idle(3);
        chk("r37_count", wlog.size(), 4);
        if (wlog.size() == 4) begin
            for (int i = 0; i < 4; i++) chk("r37_addr", wlog[i], i);
            chk("r37_d0", dlog[0], 8'h11); chk("r37_d1", dlog[1], 8'h33);
            chk("r37_d2", dlog[2], 8'h55); chk("r37_d3", dlog[3], 8'h66);
        end

        // Rejected commands
        clear_logs();
        send_cmd(630, 0, 11, 1); idle(2);
        send_cmd(0, 0, 0, 5);    idle(2);
        send_cmd(0, 470, 5, 11); idle(1);
        send_cmd(1023, 0, 1, 1); idle(2);
        chk("r36_err_cnt", err_cnt, 4);
        chk("r36_no_write", wlog.size(), 0);
        chk("r36_no_done", done_cnt, 0);

        // Abort after two pixels
        clear_logs();
        send_cmd(0, 0, 8, 1);
        pix_valid = 1'b1; step(); step();
        abort = 1'b1;
        #1 chk("r38_pix_ready_abort", pix_ready, 0);
        step();
        abort = 1'b0; pix_valid = 1'b0;
        chk("r38_cmd_ready_after", cmd_ready, 1);
        idle(3);
        chk("r38_count", wlog.size(), 2);
        if (wlog.size() == 2) begin
            chk("r38_a0", wlog[0], 0); chk("r38_a1", wlog[1], 1);
        end
        chk("r38_no_done", done_cnt, 0);

        // Reset mid-run, then a single-pixel command
        clear_logs();
        send_cmd(0, 0, 8, 2);
        pix_valid = 1'b1; step(); step(); step();
        #2 rst_n = 1'b0;
        #1;
        chk("r39_busy", busy, 0);
        chk("r39_fb_we", fb_we, 0);
        chk("r39_fb_addr", fb_addr, 0);
        pix_valid = 1'b0;
        step(); step();
        rst_n = 1'b1;
        chk("r39_pre_count", wlog.size(), 2);
        clear_logs();
        send_cmd(5, 5, 1, 1);
        pix_valid = 1'b1; step();
        idle(3);
        chk("r39_count", wlog.size(), 1);
        if (wlog.size() == 1) chk("r39_addr", wlog[0], 3205);
        chk("r39_done_cnt", done_cnt, 1);

        // Bottom-right corner rectangle
        clear_logs();
        send_cmd(630, 470, 10, 10);
        run_pix(70, 0, 0, 2000);
        idle(2);
        chk("corner_count", wlog.size(), 100);
        if (wlog.size() == 100) begin
            chk("corner_first", wlog[0], 301430);
            chk("corner_last", wlog[99], 307199);
        end

        // Full-width band
        clear_logs();
        send_cmd(0, 0, 640, 3);
        run_pix(100, 0, 0, 3000);
        idle(2);
        chk("band_count", wlog.size(), 1920);
        if (wlog.size() == 1920) chk("band_last", wlog[1919], 1919);
        chk("band_done", done_cnt, 1);

        // Full-frame command is accepted; stream a prefix then abort
        clear_logs();
        send_cmd(0, 0, 640, 480);
        pix_valid = 1'b1;
        for (int i = 0; i < 500; i++) step();
        abort = 1'b1; step();
        idle(2);
        chk("frame_err", err_cnt, 0);
        chk("frame_count", wlog.size(), 500);
        if (wlog.size() == 500) begin
            chk("frame_first", wlog[0], 0);
            chk("frame_last", wlog[499], 499);
        end
        chk("frame_no_done", done_cnt, 0);

        // Randomized commands, stalls, aborts and command noise while running
        for (int t = 0; t < 60; t++) begin
            int x0, y0, w, h;
            x0 = ($urandom_range(0, 3) == 0) ? int'($urandom_range(600, 1023)) : int'($urandom_range(0, 639));
            y0 = ($urandom_range(0, 3) == 0) ? int'($urandom_range(450, 1023)) : int'($urandom_range(0, 479));
            w  = int'($urandom_range(0, 12));
            h  = int'($urandom_range(0, 6));
            send_cmd(x0, y0, w, h);
            if (m_mode == 1) run_pix(int'($urandom_range(30, 100)), 2, 1, 3000);
            idle(int'($urandom_range(0, 2)));
        end
        idle(3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #3000000;
        failures++;
        $display("FAIL watchdog actual=timeout required=finish");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/vga_framebuffer_writer.md
VGA_FRAMEBUFFER_WRITER -- requirements
Module: vga_framebuffer_writer

Interface
REQ-001 SHALL have parameter H_RES, default 640, framebuffer line width in pixels.
REQ-002 SHALL have parameter V_RES, default 480, framebuffer line count.
REQ-003 SHALL have parameter DATA_W, default 8, pixel data width.
REQ-004 SHALL have port clk  input  1  single clock; all logic rising-edge.
REQ-005 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port cmd_valid  input  1  rectangle command offered.
REQ-007 SHALL have port cmd_ready  output  1  command accepted when high with cmd_valid.
REQ-008 SHALL have ports cmd_x0, cmd_y0, cmd_w, cmd_h  input  10 each  rectangle origin and size in pixels.
REQ-009 SHALL have port pix_valid  input  1  pixel offered.
REQ-010 SHALL have port pix_ready  output  1  pixel accepted when high with pix_valid.
REQ-011 SHALL have port pix_data  input  DATA_W  pixel value.
REQ-012 SHALL have port fb_we  output  1  framebuffer write strobe.
REQ-013 SHALL have port fb_addr  output  19  framebuffer write address, linear y*H_RES+x.
REQ-014 SHALL have port fb_data  output  DATA_W  framebuffer write data.
REQ-015 SHALL have port abort  input  1  synchronous cancel of the active rectangle.
REQ-016 SHALL have ports busy, done, err  output  1 each  status: RUN active, completion pulse, rejected-command pulse.

Function
REQ-017 SHALL implement FSM states IDLE, RUN, DONE.
REQ-018 SHALL drive cmd_ready = (state==IDLE), combinational.
REQ-019 SHALL drive pix_ready = (state==RUN) && !abort, combinational.
REQ-020 SHALL, in IDLE on cmd handshake, reject the command if cmd_w==0, cmd_h==0, cmd_x0+cmd_w>H_RES or cmd_y0+cmd_h>V_RES; comparisons are evaluated at 11 bits without overflow.
REQ-021 SHALL, on rejection, pulse err for exactly 1 cycle, issue no fb_we, and remain in IDLE.
REQ-022 SHALL, on acceptance, latch x0, w, and h, set col=0, row=0, and row_base=y0*H_RES+x0 as a 19-bit value computed with shifts/adds (y0<<9 + y0<<7 for 640), then enter RUN the next cycle.
REQ-023 SHALL, in RUN, keep busy=1.
REQ-024 SHALL, on each pix handshake, register fb_we=1, fb_addr=row_base+col, and fb_data=pix_data, visible the cycle after the handshake (1-cycle latency).
REQ-025 SHALL drive fb_we=0 in every cycle not immediately following a pix handshake, and hold fb_addr/fb_data at their last values.
REQ-026 SHALL, per handshake, increment col; at col==w-1, set col=0, increment row, and add H_RES to row_base.
REQ-027 SHALL, on the handshake with row==h-1 and col==w-1, go to DONE; that pixel's fb_we occurs in the DONE cycle.
REQ-028 SHALL, in DONE, pulse done=1 for 1 cycle, then return to IDLE; done shall not coincide with err.
REQ-029 SHALL, on abort=1 in RUN, accept no pixel that cycle, return to IDLE next cycle, and assert no done; abort is ignored in IDLE and DONE.
REQ-030 SHALL ensure fb_addr never exceeds H_RES*V_RES-1 (307199 at defaults).
REQ-031 SHALL, with pix_valid low, stall without changing col, row, or row_base.

Reset
REQ-032 SHALL, while rst_n=0 (asynchronously), force state=IDLE, fb_we=0, fb_addr=0, fb_data=0, done=0, err=0, busy=0, and all counters to 0; cmd_ready then reads 1 and pix_ready 0.
REQ-033 SHALL, on reset asserted mid-RUN, discard the rectangle with no further fb_we after the reset edge.

Verification
REQ-034 SHALL cover: cmd (10,2,3,2), pix_valid constant 1 -> fb_addr 1290,1291,1292,1930,1931,1932 on consecutive fb_we cycles; done 1 cycle after the 1932 write cycle.
REQ-035 SHALL cover: cmd (0,0,640,480) -> 307200 fb_we, first addr 0, last 307199; err never asserted.
REQ-036 SHALL cover: cmd (630,0,11,1) -> err=1 for 1 cycle, fb_we stays 0, cmd_ready stays 1; likewise cmd_w=0 -> err.
REQ-037 SHALL cover: cmd (0,0,4,1), pix_valid 1,0,1,0,1,1 -> fb_we exactly 1 cycle after each handshake, addrs 0,1,2,3, fb_data matching the inputs.
REQ-038 SHALL cover: cmd (0,0,8,1), abort after 2 pixels -> addrs 0,1 only, pix_ready low in the abort cycle, no done, cmd_ready=1 next cycle.
REQ-039 SHALL cover: rst_n low mid-RUN -> busy, fb_we, and fb_addr=0 immediately; new cmd (5,5,1,1) after release -> single write at addr 3205.
